// File: rtl/bus_protocol_master.sv
// Byte-at-a-time bus master: IDLE/SEND/GAP handshake with dAck window, timeout and error pulses.
// Define BUS_MASTER_RETRY_EN to resend a failed byte once before reporting tx_err.
module bus_protocol_master (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       src_valid,
  input  logic [7:0] src_data,
  output logic       src_ready,
  output logic       dValid,
  output logic [7:0] data,
  input  logic       dAck,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  localparam logic [2:0] AckFirst = 3'd2;  // earliest legal acknowledge beat
  localparam logic [2:0] BeatLast = 3'd4;  // final beat before timeout

  state_e     state_q, state_d;
  logic [2:0] beat_cnt_q, beat_cnt_d;
  logic       dvalid_q, dvalid_d;
  logic [7:0] data_q, data_d;
  logic       tx_done_q, tx_done_d;
  logic       tx_err_q, tx_err_d;
`ifdef BUS_MASTER_RETRY_EN
  logic       retry_q, retry_d;
`endif

  assign src_ready = (state_q == StIdle);
  assign dValid    = dvalid_q;
  assign data      = data_q;
  assign tx_done   = tx_done_q;
  assign tx_err    = tx_err_q;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    dvalid_d   = dvalid_q;
    data_d     = data_q;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
`ifdef BUS_MASTER_RETRY_EN
    retry_d    = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (src_valid) begin
          data_d     = src_data;
          dvalid_d   = 1'b1;
          beat_cnt_d = 3'd0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (dAck && (beat_cnt_q >= AckFirst)) begin
          dvalid_d  = 1'b0;
          tx_done_d = 1'b1;
          state_d   = StGap;
`ifdef BUS_MASTER_RETRY_EN
          retry_d   = 1'b0;
`endif
        end else if (dAck || (beat_cnt_q == BeatLast)) begin
          // Early acknowledge or timeout.
          dvalid_d = 1'b0;
          state_d  = StGap;
`ifdef BUS_MASTER_RETRY_EN
          if (retry_q) begin
            tx_err_d = 1'b1;
            retry_d  = 1'b0;
          end else begin
            retry_d  = 1'b1;
          end
`else
          tx_err_d = 1'b1;
`endif
        end else begin
          beat_cnt_d = beat_cnt_q + 3'd1;
        end
      end
      StGap: begin
        state_d = StIdle;
`ifdef BUS_MASTER_RETRY_EN
        // A pending retry resends the held byte without reopening src_ready.
        if (retry_q) begin
          state_d    = StSend;
          dvalid_d   = 1'b1;
          beat_cnt_d = 3'd0;
        end
`endif
      end
      default: begin
        state_d  = StIdle;
        dvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      beat_cnt_q <= 3'd0;
      dvalid_q   <= 1'b0;
      data_q     <= 8'h00;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
`ifdef BUS_MASTER_RETRY_EN
      retry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      dvalid_q   <= dvalid_d;
      data_q     <= data_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
`ifdef BUS_MASTER_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

endmodule

// File: doc/bus_protocol_master.md
BUS_PROTOCOL_MASTER -- requirements
Module: bus_protocol_master

Interface
REQ-001 The block SHALL have a single clock and an asynchronous active-low reset, with the ports listed in REQ-002 to REQ-010.
REQ-002 clk  input  1  rising-edge clock; all flops SHALL be clocked on it.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 src_valid  input  1  upstream byte available.
REQ-005 src_data  input  8  upstream byte; captured when src_valid && src_ready.
REQ-006 src_ready  output  1  master can accept a byte; high only in IDLE.
REQ-007 dValid  output  1  bus data valid, registered.
REQ-008 data  output  8  bus data, registered.
REQ-009 dAck  input  1  target acceptance, sampled on posedge clk.
REQ-010 tx_done, tx_err  output  1 each  one-cycle registered pulses: transfer acknowledged / transfer aborted.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, SEND and GAP; sampled edge T0 is the first edge at which dValid is seen high; beat_cnt (3 bits) counts sampled dValid-high edges from 0.
REQ-012 In IDLE, on an edge with src_valid && src_ready: data <= src_data, dValid <= 1, beat_cnt <= 0, next state SEND.
REQ-013 data SHALL remain unchanged and free of X/Z from the capturing edge until dValid falls.
REQ-014 In SEND, a dAck seen at beat_cnt 0 or 1 (T0, T1) SHALL be a protocol error: dValid <= 0, tx_err pulse, next state GAP.
REQ-015 In SEND, a dAck seen at beat_cnt 2..4 (T2..T4) SHALL complete the transfer: dValid <= 0 at that edge, so it is sampled low the next clock; tx_done pulse; next state GAP.
REQ-016 In SEND, no dAck at beat_cnt 4 (T4) SHALL be a timeout: dValid <= 0, tx_err pulse, next state GAP.
REQ-017 In SEND without dAck at beat_cnt < 4: beat_cnt <= beat_cnt + 1, dValid held at 1; beat_cnt SHALL never exceed 4.
REQ-018 GAP SHALL last exactly one clock with dValid = 0, then go to IDLE, guaranteeing at least 2 low sampled edges between transfers.
REQ-019 src_ready SHALL be combinational from state (IDLE only); src_valid in any other state SHALL be ignored.
REQ-020 dAck while in IDLE or GAP SHALL be ignored, with no output change.
REQ-021 Protocol guaranteed on bus: dValid high 3..5 sampled edges (T0..T2-T4), falls the clock after the dAck rise; tx_done and tx_err SHALL never both be high.

Reset
REQ-022 On reset_n low, asynchronously: state IDLE, dValid 0, data 8'h00, beat_cnt 0, tx_done 0, tx_err 0, retry flag 0.
REQ-023 Reset asserted mid-transfer SHALL drop dValid immediately, discard the byte with no tx_done/tx_err pulse, and resume in IDLE on the first edge after release.

Configuration
REQ-024 The macro BUS_MASTER_RETRY_EN SHALL select retry behaviour.
REQ-025 When BUS_MASTER_RETRY_EN is defined: on the first error (REQ-014/REQ-016), tx_err SHALL NOT pulse; after GAP the FSM SHALL return directly to SEND with the same data and beat_cnt 0 (src_ready stays low); the retry flag SHALL clear on tx_done or tx_err; a second failure SHALL pulse tx_err.
REQ-026 When BUS_MASTER_RETRY_EN is undefined: no retry flag SHALL exist and every error SHALL pulse tx_err immediately.

Verification
REQ-027 src_data=8'hA5, dAck high at T2 -> dValid high T0-T2, low T3; data=8'hA5 throughout; tx_done pulse; src_ready high again at T4.
REQ-028 dAck at T4 -> dValid high 5 sampled edges, tx_done; dAck never -> dValid low at T5, tx_err pulse (retry off).
REQ-029 dAck at T1 -> tx_err, dValid low at T2; with BUS_MASTER_RETRY_EN the same byte is resent after a 1-clock gap, and dAck at its T2 -> tx_done only.
REQ-030 Back-to-back: src_valid held high with bytes 8'h01, 8'h02, dAck at T3 each -> dValid low for exactly 2 sampled edges between transfers; both bytes delivered in order.
REQ-031 reset_n low at T1 of a transfer -> dValid 0 asynchronously, no pulse; after release, a new byte 8'h3C transfers normally.
REQ-032 Random legal dAck timing with 1000 transfers -> zero dValid-width, stability or dAck-ordering property failures.
